// File: rtl/shift_add_mult_ctrl.sv
// shift_add_mult_ctrl: shift-and-add multiplier controller driving an external right-shift register
// Optional early termination when the remaining multiplier bits are zero: define EARLY_TERM_EN.
module shift_add_mult_ctrl #(
    parameter int N = 7,
    parameter int M = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [M-1:0]   multiplicand,
    input  logic [N-1:0]   multiplier,
    output logic           sr_load_en,
    output logic           sr_shift_en,
    output logic [N-1:0]   sr_data_in,
    input  logic [N-1:0]   sr_data,
    output logic [N+M-1:0] product,
    output logic           busy,
    output logic           done
);
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] RUN  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]     state;
    logic [N+M-1:0] acc;
    logic [N+M-1:0] msh;
    logic [CW-1:0]  cnt;
    logic [M-1:0]   a_q;
    logic [N-1:0]   b_q;
    logic           run_exit;

`ifdef EARLY_TERM_EN
    assign run_exit = (cnt == LAST) || ~|sr_data[N-1:1];
`else
    logic unused_sr_hi;
    assign unused_sr_hi = ^sr_data[N-1:1];
    assign run_exit = (cnt == LAST);
`endif

    assign sr_load_en  = (state == LOAD);
    assign sr_shift_en = (state == RUN);
    assign sr_data_in  = b_q;
    assign product     = acc;
    assign busy        = (state != IDLE);
    assign done        = (state == DONE);

    // sequencing, operand capture and the shift-add datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            acc   <= '0;
            msh   <= '0;
            cnt   <= '0;
            a_q   <= '0;
            b_q   <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    a_q   <= multiplicand;
                    b_q   <= multiplier;
                    state <= LOAD;
                end
                LOAD: begin
                    acc   <= '0;
                    msh   <= {{N{1'b0}}, a_q};
                    cnt   <= '0;
                    state <= RUN;
                end
                RUN: begin
                    if (sr_data[0]) acc <= acc + msh;
                    msh <= msh << 1;
                    cnt <= cnt + 1'b1;
                    if (run_exit) state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_shift_add_mult_ctrl.sv
// tb_shift_add_mult_ctrl: directed self-checking bench with a behavioural shift register
module tb_shift_add_mult_ctrl;
    logic        clk = 0;
    logic        rst = 1;
    logic        start = 0;
    logic [7:0]  multiplicand = 0;
    logic [6:0]  multiplier = 0;
    logic        sr_load_en, sr_shift_en, busy, done;
    logic [6:0]  sr_data_in;
    logic [6:0]  sr_data = 0;
    logic [14:0] product;
    int checks = 0;
    int errors = 0;

    shift_add_mult_ctrl #(.N(7), .M(8)) dut (
        .clk(clk), .rst(rst), .start(start),
        .multiplicand(multiplicand), .multiplier(multiplier),
        .sr_load_en(sr_load_en), .sr_shift_en(sr_shift_en),
        .sr_data_in(sr_data_in), .sr_data(sr_data),
        .product(product), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // external right-shift register
    always @(posedge clk) begin
        if (sr_load_en) sr_data <= sr_data_in;
        else if (sr_shift_en) sr_data <= sr_data >> 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // one multiply: start sampled at edge 0, then watch until a few cycles past done
    task automatic run_mul(input logic [7:0] a, input logic [6:0] b, input int exp_p,
                           input int k, input bit second_start);
        int lat, shifts, loads, dones, ovl, busy_cnt, p_done, exp_lat, exp_shifts;
`ifdef EARLY_TERM_EN
        exp_lat = k + 2;
        exp_shifts = k + 1;
`else
        exp_lat = 8;
        exp_shifts = 7;
`endif
        lat = -1; shifts = 0; loads = 0; dones = 0; ovl = 0; busy_cnt = 0; p_done = -1;
        @(negedge clk);
        multiplicand = a;
        multiplier = b;
        start = 1;
        @(posedge clk);
        #1;
        start = 0;
        multiplicand = 8'hA5;
        multiplier = 7'h5A;
        for (int e = 0; e < 60; e++) begin
            if (sr_shift_en) shifts++;
            if (sr_load_en) loads++;
            if (sr_load_en && sr_shift_en) ovl++;
            if (busy) busy_cnt++;
            if (done) begin
                dones++;
                if (lat < 0) begin
                    lat = e;
                    p_done = int'(product);
                end
            end
            if (second_start && e == 2) begin
                start = 1;
                multiplicand = 9;
                multiplier = 9;
            end else start = 0;
            if (lat >= 0 && e > lat + 3) break;
            @(posedge clk);
            #1;
        end
        check($sformatf("latency %0dx%0d", a, b), lat, exp_lat);
        check($sformatf("product_at_done %0dx%0d", a, b), p_done, exp_p);
        check($sformatf("product_held %0dx%0d", a, b), {17'd0, product}, exp_p);
        check($sformatf("shift_cycles %0dx%0d", a, b), shifts, exp_shifts);
        check($sformatf("load_cycles %0dx%0d", a, b), loads, 1);
        check($sformatf("done_pulses %0dx%0d", a, b), dones, 1);
        check($sformatf("busy_cycles %0dx%0d", a, b), busy_cnt, exp_lat + 1);
        check($sformatf("strobe_overlap %0dx%0d", a, b), ovl, 0);
        check($sformatf("idle_after %0dx%0d", a, b), {31'd0, busy}, 0);
    endtask

    initial begin
        int dcount;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", {31'd0, busy}, 0);
        check("reset_done", {31'd0, done}, 0);
        check("reset_strobes", {30'd0, sr_load_en, sr_shift_en}, 0);
        check("reset_product", {17'd0, product}, 0);
        check("reset_sr_data_in", {25'd0, sr_data_in}, 0);
        rst = 0;

        run_mul(8'd5, 7'd3, 15, 1, 0);
        run_mul(8'd255, 7'd127, 32385, 6, 0);
        run_mul(8'd200, 7'd0, 0, 0, 0);
        run_mul(8'd13, 7'd1, 13, 0, 0);
        run_mul(8'd1, 7'd64, 64, 6, 0);
        run_mul(8'd5, 7'd3, 15, 1, 1);

        // reset during the 4th RUN cycle of 100x100
        @(negedge clk);
        multiplicand = 100;
        multiplier = 100;
        start = 1;
        @(posedge clk);
        #1;
        start = 0;
        repeat (4) @(posedge clk);
        #1;
        check("abort_in_run", {31'd0, sr_shift_en}, 1);
        rst = 1;
        @(posedge clk);
        #1;
        rst = 0;
        check("abort_busy", {31'd0, busy}, 0);
        check("abort_product", {17'd0, product}, 0);
        check("abort_strobes", {30'd0, sr_load_en, sr_shift_en}, 0);
        dcount = 0;
        for (int i = 0; i < 10; i++) begin
            if (done || busy) dcount++;
            @(posedge clk);
            #1;
        end
        check("abort_no_done", dcount, 0);
        run_mul(8'd6, 7'd7, 42, 2, 0);

        // reset wins over start on the same edge
        @(negedge clk);
        multiplicand = 3;
        multiplier = 3;
        start = 1;
        rst = 1;
        @(posedge clk);
        #1;
        start = 0;
        rst = 0;
        check("rst_priority_busy", {31'd0, busy}, 0);
        check("rst_priority_product", {17'd0, product}, 0);
        run_mul(8'd9, 7'd9, 81, 3, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
